// File: rtl/mem_port_arbiter_if.sv
// Requester, bank and status signals of mem_port_arbiter bundled as one interface.
// The slave modport is the arbiter's view; the master modport is the requesters' and bank's view.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              inReqA;
    logic              inWeA;
    logic [ADDR_W-1:0] inAddrA;
    logic [DATA_W-1:0] inDataA;
    logic              outAckA;
    logic [DATA_W-1:0] outDataA;

    logic              inReqB;
    logic              inWeB;
    logic [ADDR_W-1:0] inAddrB;
    logic [DATA_W-1:0] inDataB;
    logic              outAckB;
    logic [DATA_W-1:0] outDataB;

    logic              outMemEn;
    logic              outMemWe;
    logic [ADDR_W-1:0] outMemAddr;
    logic [DATA_W-1:0] outMemData;
    logic [DATA_W-1:0] inMemData;

    logic              outBusy;

    modport slave (
        input  inReqA, inWeA, inAddrA, inDataA,
        output outAckA, outDataA,
        input  inReqB, inWeB, inAddrB, inDataB,
        output outAckB, outDataB,
        output outMemEn, outMemWe, outMemAddr, outMemData,
        input  inMemData,
        output outBusy
    );

    modport master (
        output inReqA, inWeA, inAddrA, inDataA,
        input  outAckA, outDataA,
        output inReqB, inWeB, inAddrB, inDataB,
        input  outAckB, outDataB,
        input  outMemEn, outMemWe, outMemAddr, outMemData,
        output inMemData,
        input  outBusy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer giving requesters A (fetch) and B (execute) one access
// each to a single-port register bank: IDLE -> ACCESS -> RESP, all outputs registered.
module mem_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic                inClk,
    input logic                inZero,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;        // 0 = A has priority, 1 = B
    logic              gnt_q, gnt_d;        // 0 = A granted, 1 = B granted
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              ack_a_q, ack_a_d;
    logic              ack_b_q, ack_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              busy_q, busy_d;

    logic              grant;
    logic              sel;
    logic [DATA_W-1:0] rsp_data;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_data_d = '0;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        grant      = 1'b0;
        sel        = ptr_q;
        rsp_data   = we_q ? wdata_q : bus.inMemData;

        case (state_q)
            IDLE: begin
                if (bus.inReqA || bus.inReqB) begin
                    grant = 1'b1;
                    sel   = (bus.inReqA && bus.inReqB) ? ptr_q : bus.inReqB;
                end
            end
            ACCESS: begin
                state_d = RESP;
                ptr_d   = ~gnt_q;
                if (gnt_q) begin
                    ack_b_d  = 1'b1;
                    data_b_d = rsp_data;
                end else begin
                    ack_a_d  = 1'b1;
                    data_a_d = rsp_data;
                end
            end
            RESP: begin
                // Only the other requester may be granted here; the acked one is ignored.
                state_d = IDLE;
                if (gnt_q ? bus.inReqA : bus.inReqB) begin
                    grant = 1'b1;
                    sel   = ~gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bank outputs are loaded together with the latched operands so they are valid in ACCESS.
        if (grant) begin
            state_d    = ACCESS;
            gnt_d      = sel;
            we_d       = sel ? bus.inWeB   : bus.inWeA;
            addr_d     = sel ? bus.inAddrB : bus.inAddrA;
            wdata_d    = sel ? bus.inDataB : bus.inDataA;
            mem_en_d   = 1'b1;
            mem_we_d   = we_d;
            mem_addr_d = addr_d;
            mem_data_d = wdata_d;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge inClk or negedge inZero) begin
        if (!inZero) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.outAckA    = ack_a_q;
    assign bus.outDataA   = data_a_q;
    assign bus.outAckB    = ack_b_q;
    assign bus.outDataB   = data_b_q;
    assign bus.outMemEn   = mem_en_q;
    assign bus.outMemWe   = mem_we_q;
    assign bus.outMemAddr = mem_addr_q;
    assign bus.outMemData = mem_data_q;
    assign bus.outBusy    = busy_q;
endmodule
